// File: rtl/dbus_uart_tx_pkg.sv
// Shared definitions for the dBus transmit UART: register offsets, STATUS bit layout, FSM encoding.
// No logic; imported by the UART top.
package dbus_uart_tx_pkg;

  localparam logic [1:0] ADDR_TXDATA  = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_DIVISOR = 2'd2;

  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_OVF   = 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  function automatic logic [31:0] packStatus(input logic full, input logic empty,
                                             input logic busy, input logic ovf);
    logic [31:0] s;
    s            = '0;
    s[STAT_FULL] = full;
    s[STAT_EMPTY]= empty;
    s[STAT_BUSY] = busy;
    s[STAT_OVF]  = ovf;
    return s;
  endfunction

endpackage

// File: rtl/dbus_uart_tx_if.sv
// dBus peripheral command/read-data bundle; master is the CPU side, slave the peripheral.
// Reads return rdata one cycle after the command; no stall signal exists.
interface dbus_uart_tx_if;
  logic        cmd_valid;
  logic        cmd_wr;
  logic [1:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [31:0] rdata;

  modport master (output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, input rdata);
  modport slave  (input cmd_valid, cmd_wr, cmd_addr, cmd_wdata, output rdata);
endinterface

// File: rtl/dbus_uart_tx_sync_fifo.sv
// Generic synchronous FIFO, show-ahead dout, zero-latency flags.
// Push on full is accepted only with a same-cycle pop; pop on empty is ignored.
module dbus_uart_tx_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;
  logic             doPush;
  logic             doPop;

  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);

  // Extra MSB distinguishes full from empty when the index bits match.
  assign empty = (wrPtr == rdPtr);
  assign full  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign dout  = mem[rdPtr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + (AW+1)'(1);
      if (doPop)  rdPtr <= rdPtr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/dbus_uart_tx.sv
// Transmit-only 8N1 UART on the dBus: CPU pushes bytes into a FIFO, shifter drains them at div clk/bit.
// Reads answer one cycle after the command; a TXDATA write to a full FIFO is dropped and flags overflow.
module dbus_uart_tx
  import dbus_uart_tx_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int FIFO_AW     = 3,
  parameter int DEFAULT_DIV = 434,
  parameter int DIV_BITS    = 16
) (
  input  logic           clk,
  input  logic           reset,
  dbus_uart_tx_if.slave  bus,
  output logic           txd,
  output logic           irq_empty
);

  logic [1:0]          state, nextState;
  logic [DIV_BITS-1:0] divReg;
  logic [DIV_BITS-1:0] timer, nextTimer;
  logic [2:0]          bitIdx, nextBitIdx;
  logic [7:0]          shifter, nextShifter;
  logic                nextTxd;
  logic                pop;
  logic                overflow;
  logic [31:0]         rdataReg;
  logic [31:0]         readMux;

  logic                fifoFull, fifoEmpty;
  logic [7:0]          fifoDout;

  logic isWrite, isRead, txPush, pushOk, bitEnd;
  logic [DIV_BITS-1:0] reload;

  wire unusedBits = &{1'b0, bus.cmd_wdata[31:DIV_BITS]};

  assign isWrite = bus.cmd_valid && bus.cmd_wr;
  assign isRead  = bus.cmd_valid && !bus.cmd_wr;
  assign txPush  = isWrite && (bus.cmd_addr == ADDR_TXDATA);
  assign pushOk  = txPush && (!fifoFull || pop);
  assign bitEnd  = (timer == '0);
  // Timer is loaded only at a bit start, so divisor writes never stretch a bit in flight.
  assign reload  = divReg - DIV_BITS'(1);

  dbus_uart_tx_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) txFifo (
    .clk   (clk),
    .reset (reset),
    .push  (txPush),
    .pop   (pop),
    .din   (bus.cmd_wdata[7:0]),
    .dout  (fifoDout),
    .full  (fifoFull),
    .empty (fifoEmpty)
  );

  always_comb begin
    nextState   = state;
    nextTimer   = timer;
    nextBitIdx  = bitIdx;
    nextShifter = shifter;
    pop         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifoEmpty) begin
          pop         = 1'b1;
          nextShifter = fifoDout;
          nextTimer   = reload;
          nextState   = ST_START;
        end
      end
      ST_START: begin
        if (bitEnd) begin
          nextState  = ST_DATA;
          nextBitIdx = '0;
          nextTimer  = reload;
        end else begin
          nextTimer = timer - DIV_BITS'(1);
        end
      end
      ST_DATA: begin
        if (bitEnd) begin
          nextTimer = reload;
          if (bitIdx == 3'd7) begin
            nextState = ST_STOP;
          end else begin
            nextBitIdx  = bitIdx + 3'd1;
            nextShifter = shifter >> 1;
          end
        end else begin
          nextTimer = timer - DIV_BITS'(1);
        end
      end
      default: begin
        if (bitEnd) begin
          // Chain straight into the next start bit when more data waits.
          if (!fifoEmpty) begin
            pop         = 1'b1;
            nextShifter = fifoDout;
            nextTimer   = reload;
            nextState   = ST_START;
          end else begin
            nextState = ST_IDLE;
          end
        end else begin
          nextTimer = timer - DIV_BITS'(1);
        end
      end
    endcase
  end

  always_comb begin
    nextTxd = 1'b1;
    if (nextState == ST_START)     nextTxd = 1'b0;
    else if (nextState == ST_DATA) nextTxd = nextShifter[0];
  end

  always_comb begin
    readMux = '0;
    case (bus.cmd_addr)
      ADDR_STATUS:  readMux = packStatus(fifoFull, fifoEmpty, state != ST_IDLE, overflow);
      ADDR_DIVISOR: readMux = 32'(divReg);
      default:      readMux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      timer     <= '0;
      bitIdx    <= '0;
      shifter   <= '0;
      txd       <= 1'b1;
      divReg    <= DIV_BITS'(DEFAULT_DIV);
      overflow  <= 1'b0;
      rdataReg  <= '0;
      irq_empty <= 1'b1;
    end else begin
      state     <= nextState;
      timer     <= nextTimer;
      bitIdx    <= nextBitIdx;
      shifter   <= nextShifter;
      txd       <= nextTxd;
      irq_empty <= fifoEmpty && (state == ST_IDLE);
      if (isWrite && bus.cmd_addr == ADDR_DIVISOR) begin
        divReg <= (bus.cmd_wdata[DIV_BITS-1:0] == '0) ? DIV_BITS'(1)
                                                      : bus.cmd_wdata[DIV_BITS-1:0];
      end
      if (isWrite && bus.cmd_addr == ADDR_STATUS && bus.cmd_wdata[STAT_OVF]) overflow <= 1'b0;
      if (txPush && !pushOk) overflow <= 1'b1;
      if (isRead) rdataReg <= readMux;
    end
  end

  assign bus.rdata = rdataReg;

endmodule
